// File: rtl/clk_copy_pkg.sv
// -----------------------------------------------------------------------------
// clk_copy_pkg
// Shared definitions for the clk_copy arbiter:
//   - state_t     : arbiter FSM encoding (IDLE / RUN / GUARD)
//   - DEF_*       : default parameter values for clk_copy_arbiter
//   - MAX_NREQ    : widest requester vector supported by onehot()
//   - onehot(idx) : index -> one-hot vector (MAX_NREQ bits, caller truncates)
// -----------------------------------------------------------------------------
package clk_copy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam int MAX_NREQ       = 16;
  localparam int DEF_NREQ       = 4;
  localparam int DEF_MIN_ON     = 4;
  localparam int DEF_GUARD      = 2;
  localparam int DEF_TMO_CYCLES = 64;

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [3:0] idx);
    logic [MAX_NREQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/clk_copy_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker, shared by the resource arbiters.
// Returns the first set request bit at or after ptr, wrapping NREQ-1 -> 0.
// Ports:
//   req   [NREQ] in   request vector
//   ptr   [PW]   in   round-robin start index (must be < NREQ)
//   valid        out  at least one request is set
//   idx   [PW]   out  winning index (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_pick
  import clk_copy_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  logic [NREQ-1:0] rot;
  int              sum;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = 0;
    // Rotate so that bit 0 of rot is req[ptr]; bit i is req[(ptr+i) % NREQ].
    rot   = NREQ'({req, req} >> ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        sum   = int'(ptr) + i;
        if (sum >= NREQ) sum = sum - NREQ;
        idx   = PW'(sum);
      end
    end
  end

endmodule

// File: rtl/clk_copy_arbiter.sv
// -----------------------------------------------------------------------------
// clk_copy_arbiter
// Shares one clk_copy instance between NREQ requesters using a level req/gnt
// handshake. copy_en is a registered signal so the copy starts and stops on
// clk edges. Each grant lasts at least MIN_ON cycles, consecutive owners are
// separated by exactly GUARD dead cycles, and the next owner is chosen
// round-robin starting after the previous owner.
//
// Optional feature macro: CLK_COPY_ARB_TMO_EN
//   defined   : a grant is forcibly released after TMO_CYCLES copy_en cycles,
//               tmo pulses for one cycle (the first dead cycle)
//   undefined : no time limit, tmo is constant 0
//
// Ports:
//   clk      in   system clock, all state on posedge
//   rst      in   asynchronous active-high reset
//   req      in   [NREQ] level request per requester
//   gnt      out  [NREQ] one-hot grant, zero when nobody owns the copy
//   owner    out  [$clog2(NREQ)] current/last owner index
//   copy_en  out  copy enable, high only while a grant is active
//   busy     out  high whenever the arbiter is not idle
//   tmo      out  one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module clk_copy_arbiter
  import clk_copy_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int MIN_ON     = DEF_MIN_ON,
  parameter int GUARD      = DEF_GUARD,
  parameter int TMO_CYCLES = DEF_TMO_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    copy_en,
  output logic                    busy,
  output logic                    tmo
);

  localparam int PW = $clog2(NREQ);

`ifdef CLK_COPY_ARB_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // on_cnt only has to count as far as the largest value it is compared with.
  localparam int ON_MAX = TMO_EN ? TMO_CYCLES : MIN_ON;
  localparam int ON_W   = $clog2(ON_MAX + 1);
  localparam int GW     = $clog2(GUARD + 1);

  localparam logic [ON_W-1:0] MIN_ON_C = ON_W'(MIN_ON);
  localparam logic [ON_W-1:0] ON_MAX_C = ON_W'(ON_MAX);
  localparam logic [GW-1:0]   GUARD_C  = GW'(GUARD);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

  state_t            state_q,     state_d;
  logic [ON_W-1:0]   on_cnt_q,    on_cnt_d;
  logic [GW-1:0]     guard_cnt_q, guard_cnt_d;
  logic [PW-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [NREQ-1:0]   gnt_q,       gnt_d;
  logic [PW-1:0]     owner_q,     owner_d;
  logic              copy_en_q,   copy_en_d;
  logic              tmo_q,       tmo_d;

  logic              pick_valid;
  logic [PW-1:0]     pick_idx;
  logic              tmo_hit;
  logic              grant_now;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef CLK_COPY_ARB_TMO_EN
  // on_cnt saturates at TMO_CYCLES, so equality marks the last allowed cycle.
  assign tmo_hit = (on_cnt_q == ON_MAX_C);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    on_cnt_d    = on_cnt_q;
    guard_cnt_d = guard_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    copy_en_d   = copy_en_q;
    tmo_d       = 1'b0;
    grant_now   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        grant_now = pick_valid;
      end

      ST_RUN: begin
        if (on_cnt_q != ON_MAX_C) on_cnt_d = on_cnt_q + ON_W'(1);
        // A dropped req inside the MIN_ON window is simply not looked at,
        // so a drop-and-reraise behaves like a held request.
        if (tmo_hit || (!req[owner_q] && on_cnt_q >= MIN_ON_C)) begin
          state_d     = ST_GUARD;
          gnt_d       = '0;
          copy_en_d   = 1'b0;
          guard_cnt_d = GW'(1);
          rr_ptr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
          // Only flag a timeout when the owner still wanted the copy.
          tmo_d       = tmo_hit & req[owner_q];
        end
      end

      ST_GUARD: begin
        // Arbitrate in the last dead cycle so the gap is exactly GUARD cycles.
        if (guard_cnt_q == GUARD_C) begin
          grant_now = pick_valid;
          if (!pick_valid) state_d = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (grant_now) begin
      state_d   = ST_RUN;
      gnt_d     = NREQ'(onehot(4'(pick_idx)));
      owner_d   = pick_idx;
      copy_en_d = 1'b1;
      on_cnt_d  = ON_W'(1);
    end
  end

  // NOTE: asynchronous reset clears gnt/copy_en immediately, without waiting
  // for a clock edge, so a reset in the middle of a grant stops the copy at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      on_cnt_q    <= '0;
      guard_cnt_q <= '0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      owner_q     <= '0;
      copy_en_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      on_cnt_q    <= on_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      copy_en_q   <= copy_en_d;
      tmo_q       <= tmo_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign copy_en = copy_en_q;
  assign busy    = (state_q != ST_IDLE);
  assign tmo     = tmo_q;

endmodule
